channel_readout_arbiter: RTL and testbench



---
 rtl/readout_pkg.sv | 44 ++++
 rtl/rr_arbiter_4.sv | 26 ++
 rtl/channel_readout_arbiter.sv | 124 ++++++++++++
 tb/tb_channel_readout_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types and framing constants for the channel readout arbiter.
// beat_word() maps a 120-bit FIFO word onto the four 32-bit beats of a frame.
package readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_SEND    = 2'd3
    } state_t;

    localparam int CH_DATA_W       = 120;
    localparam int OUT_W           = 32;
    localparam int BEATS_PER_FRAME = 4;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_FRAME - 1);

    localparam int HDR_TAG_LSB  = 28;
    localparam int HDR_CH_LSB   = 26;
    localparam int HDR_DATA_W   = 24;
    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    // Header beat carries tag, channel and the top 24 data bits; the rest follow MSB first.
    function automatic logic [OUT_W-1:0] beat_word(
        input logic [1:0]           beat,
        input logic [CH_DATA_W-1:0] word,
        input logic [3:0]           tag,
        input logic [1:0]           ch
    );
        logic [OUT_W-1:0] w;
        w = '0;
        case (beat)
            2'd0: begin
                w[HDR_TAG_LSB +: 4]  = tag;
                w[HDR_CH_LSB +: 2]   = ch;
                w[HDR_DATA_W-1:0]    = word[CH_DATA_W-1 -: HDR_DATA_W];
            end
            2'd1:    w = word[95:64];
            2'd2:    w = word[63:32];
            default: w = word[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Rotating-priority select over four requesters: the scan starts at rr_ptr and wraps.
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] rr_ptr,
    output logic [1:0] gnt_idx,
    output logic       gnt_any
);

    logic [3:0] rot;

    // rot[k] is the request of the channel k places after rr_ptr.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot[gi] = req[rr_ptr + 2'(gi)];
    end

    always_comb begin
        gnt_idx = rr_ptr;
        gnt_any = |req;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_idx = rr_ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/channel_readout_arbiter.sv
// Drains four 120-bit channel FIFOs round-robin into a 32-bit stream,
// one 4-beat frame per FIFO word, with a per-grant burst limit.
module channel_readout_arbiter
    import readout_pkg::*;
#(
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] HDR_TAG   = HDR_TAG_DEFAULT
) (
    input  logic                 clk160,
    input  logic                 reset_n,
    input  logic [3:0]           chan_enable,
    input  logic [CH_DATA_W-1:0] channel_data_0,
    input  logic [CH_DATA_W-1:0] channel_data_1,
    input  logic [CH_DATA_W-1:0] channel_data_2,
    input  logic [CH_DATA_W-1:0] channel_data_3,
    input  logic [3:0]           channel_fifo_empty,
    output logic [3:0]           channel_data_read,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [1:0]           grant_ch,
    output logic                 busy,
    output logic [15:0]          frame_count
);

    state_t               state_reg;
    logic [1:0]           rr_ptr_reg;
    logic [7:0]           burst_cnt_reg;
    logic [1:0]           beat_reg;
    logic [CH_DATA_W-1:0] hold_reg;

    logic [3:0]           req;
    logic [1:0]           arb_idx;
    logic                 arb_any;
    logic [CH_DATA_W-1:0] ch_data [4];
    logic [8:0]           burst_inc;
    logic                 burst_more;
    logic [1:0]           beat_next;

    assign req        = ~channel_fifo_empty & chan_enable;
    assign ch_data[0] = channel_data_0;
    assign ch_data[1] = channel_data_1;
    assign ch_data[2] = channel_data_2;
    assign ch_data[3] = channel_data_3;
    assign burst_inc  = {1'b0, burst_cnt_reg} + 9'd1;
    assign burst_more = (burst_inc < 9'(MAX_BURST)) && req[grant_ch];
    assign beat_next  = beat_reg + 2'd1;

    rr_arbiter_4 u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            rr_ptr_reg        <= 2'd0;
            burst_cnt_reg     <= 8'd0;
            beat_reg          <= 2'd0;
            hold_reg          <= '0;
            channel_data_read <= 4'd0;
            out_data          <= '0;
            out_valid         <= 1'b0;
            out_last          <= 1'b0;
            grant_ch          <= 2'd0;
            busy              <= 1'b0;
            frame_count       <= 16'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    channel_data_read <= 4'd0;
                    if (arb_any) begin
                        grant_ch          <= arb_idx;
                        burst_cnt_reg     <= 8'd0;
                        channel_data_read <= 4'b0001 << arb_idx;
                        busy              <= 1'b1;
                        state_reg         <= ST_READ;
                    end
                end
                ST_READ: begin
                    // FIFO is standard mode: the word appears during CAPTURE.
                    channel_data_read <= 4'd0;
                    state_reg         <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    hold_reg  <= ch_data[grant_ch];
                    beat_reg  <= 2'd0;
                    out_data  <= beat_word(2'd0, ch_data[grant_ch], HDR_TAG, grant_ch);
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    state_reg <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (beat_reg == LAST_BEAT) begin
                            frame_count   <= frame_count + 16'd1;
                            burst_cnt_reg <= burst_inc[7:0];
                            out_valid     <= 1'b0;
                            out_last      <= 1'b0;
                            out_data      <= '0;
                            if (burst_more) begin
                                channel_data_read <= 4'b0001 << grant_ch;
                                state_reg         <= ST_READ;
                            end else begin
                                rr_ptr_reg <= grant_ch + 2'd1;
                                busy       <= 1'b0;
                                state_reg  <= ST_IDLE;
                            end
                        end else begin
                            beat_reg <= beat_next;
                            out_data <= beat_word(beat_next, hold_reg, HDR_TAG, grant_ch);
                            out_last <= (beat_next == LAST_BEAT);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Directed bench for channel_readout_arbiter with a behavioural standard-mode FIFO per channel.
`timescale 1ns/1ps
module tb_channel_readout_arbiter;

    localparam logic [119:0] SPEC_WORD = 120'h123456_789ABCDE_F0112233_44556677;

    logic         clk160;
    logic         reset_n;
    logic [3:0]   chan_enable;
    logic [119:0] ch_data_tb [4] = '{default: '0};
    logic [3:0]   fifo_empty;
    logic [3:0]   channel_data_read;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic [1:0]   grant_ch;
    logic         busy;
    logic [15:0]  frame_count;

    int vectors = 0;
    int miscompares = 0;

    // FIFO model: the initial process pushes (fifo_wr), the clocked process pops (fifo_rd).
    logic [119:0] fifo_mem [4][32];
    int           fifo_wr [4] = '{default: 0};
    int           fifo_rd [4] = '{default: 0};
    int           strobe_cnt [4] = '{default: 0};
    int           strobe_err = 0;

    logic [31:0]  cap_data [$];
    logic         cap_last [$];
    int           cap_iter [$];
    bit           timed_out;

    channel_readout_arbiter #(.MAX_BURST(16), .HDR_TAG(4'hA)) dut (
        .clk160             (clk160),
        .reset_n            (reset_n),
        .chan_enable        (chan_enable),
        .channel_data_0     (ch_data_tb[0]),
        .channel_data_1     (ch_data_tb[1]),
        .channel_data_2     (ch_data_tb[2]),
        .channel_data_3     (ch_data_tb[3]),
        .channel_fifo_empty (fifo_empty),
        .channel_data_read  (channel_data_read),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_last           (out_last),
        .out_ready          (out_ready),
        .grant_ch           (grant_ch),
        .busy               (busy),
        .frame_count        (frame_count)
    );

    initial clk160 = 1'b0;
    always #3 clk160 = ~clk160;

    always_comb begin
        for (int i = 0; i < 4; i++) fifo_empty[i] = (fifo_rd[i] == fifo_wr[i]);
    end

    always @(posedge clk160) begin
        for (int i = 0; i < 4; i++) begin
            if (channel_data_read[i] && fifo_rd[i] != fifo_wr[i]) begin
                ch_data_tb[i] <= fifo_mem[i][fifo_rd[i] % 32];
                fifo_rd[i]    <= fifo_rd[i] + 1;
            end
        end
    end

    // Strobe monitor: more than one strobe, or a strobe to an empty FIFO, is a protocol error.
    always @(negedge clk160) begin
        for (int i = 0; i < 4; i++) begin
            if (channel_data_read[i]) strobe_cnt[i] <= strobe_cnt[i] + 1;
        end
        strobe_err <= strobe_err + (($countones(channel_data_read) > 1) ? 1 : 0)
                                 + $countones(channel_data_read & fifo_empty);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [119:0] mk_word(input int ch, input int idx);
        return {8'(8'hC0 + ch), 16'(idx), 32'(32'h1111_0000 + idx),
                32'(32'h2222_0000 + ch * 256 + idx), 32'(32'h3333_0000 + idx)};
    endfunction

    // Frame as four concatenated beats: header {tag, ch, 00, word[119:96]} then word[95:0].
    function automatic logic [127:0] exp_frame(input logic [119:0] word, input logic [1:0] ch);
        return {4'hA, ch, 2'b00, word};
    endfunction

    function automatic logic [127:0] got_frame(input int k);
        return {cap_data[4*k], cap_data[4*k+1], cap_data[4*k+2], cap_data[4*k+3]};
    endfunction

    function automatic logic [3:0] got_last(input int k);
        return {cap_last[4*k], cap_last[4*k+1], cap_last[4*k+2], cap_last[4*k+3]};
    endfunction

    task automatic push(input int ch, input logic [119:0] word);
        fifo_mem[ch][fifo_wr[ch] % 32] = word;
        fifo_wr[ch] = fifo_wr[ch] + 1;
    endtask

    task automatic collect(input int nbeats, input int budget);
        cap_data.delete();
        cap_last.delete();
        cap_iter.delete();
        timed_out = 1'b0;
        for (int it = 1; it <= budget && cap_data.size() < nbeats; it++) begin
            @(negedge clk160);
            if (out_valid && out_ready) begin
                cap_data.push_back(out_data);
                cap_last.push_back(out_last);
                cap_iter.push_back(it);
            end
        end
        if (cap_data.size() < nbeats) timed_out = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk160);
        reset_n = 1'b0;
        repeat (2) @(negedge clk160);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        out_ready = 1'b1;
        chan_enable = 4'hF;
        repeat (3) @(negedge clk160);
        vectors++;
        if ({out_valid, out_last, out_data, channel_data_read, grant_ch, busy, frame_count} !== '0) begin
            $display("FAIL reset_values: valid=%b last=%b data=%h rd=%b gnt=%0d busy=%b fc=%0d, required all zero",
                     out_valid, out_last, out_data, channel_data_read, grant_ch, busy, frame_count);
            miscompares++;
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk160);
        vectors++;
        if ({out_valid, busy, channel_data_read} !== '0) begin
            $display("FAIL idle_after_reset: valid=%b busy=%b rd=%b, required 0/0/0", out_valid, busy, channel_data_read);
            miscompares++;
        end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        logic [31:0] exp_b [4];
        exp_b = '{32'hA8123456, 32'h789ABCDE, 32'hF0112233, 32'h44556677};
        push(2, SPEC_WORD);
        @(negedge clk160);
        vectors++;
        if (channel_data_read !== 4'b0100 || out_valid !== 1'b0) begin
            $display("FAIL single_strobe: rd=%b valid=%b, required rd=0100 valid=0", channel_data_read, out_valid);
            miscompares++;
        end
        @(negedge clk160);
        vectors++;
        if (channel_data_read !== 4'b0000 || out_valid !== 1'b0) begin
            $display("FAIL single_capture: rd=%b valid=%b, required rd=0000 valid=0", channel_data_read, out_valid);
            miscompares++;
        end
        collect(4, 50);
        vectors++;
        if (timed_out || cap_iter[0] != 1) begin
            $display("FAIL single_latency: timeout=%b first beat at +%0d, required +1 after capture", timed_out, cap_iter[0]);
            miscompares++;
        end
        for (int b = 0; b < 4; b++) begin
            vectors++;
            if (cap_data[b] !== exp_b[b] || cap_last[b] !== (b == 3)) begin
                $display("FAIL single_beat%0d: got %h last=%b, required %h last=%b", b, cap_data[b], cap_last[b], exp_b[b], b == 3);
                miscompares++;
            end
            $display("single frame beat %0d data=%h last=%b", b, cap_data[b], cap_last[b]);
        end
        @(negedge clk160);
        vectors++;
        if (frame_count !== 16'd1 || strobe_cnt[2] != 1) begin
            $display("FAIL single_count: fc=%0d strobes_ch2=%0d, required 1/1", frame_count, strobe_cnt[2]);
            miscompares++;
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int c = 0; c < 4; c++) push(c, mk_word(c, 0));
        collect(16, 200);
        vectors++;
        if (timed_out) begin
            $display("FAIL rr_timeout: got %0d beats, required 16", cap_data.size());
            miscompares++;
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (got_frame(k) !== exp_frame(mk_word(k, 0), 2'(k)) || got_last(k) !== 4'b0001 ||
                cap_data[4*k][31:24] !== 8'(8'hA0 + 4 * k)) begin
                $display("FAIL rr_frame%0d: got %h, required %h", k, got_frame(k), exp_frame(mk_word(k, 0), 2'(k)));
                miscompares++;
            end
            $display("rr frame %0d header=%h", k, cap_data[4*k]);
        end
        // With the pointer back at 0, ch0 must win over ch3.
        @(negedge clk160);
        push(3, mk_word(3, 1));
        push(0, mk_word(0, 1));
        collect(8, 200);
        vectors++;
        if (timed_out || got_frame(0) !== exp_frame(mk_word(0, 1), 2'd0) ||
            got_frame(1) !== exp_frame(mk_word(3, 1), 2'd3)) begin
            $display("FAIL rr_ptr_wrap: frames %h / %h, required ch0 then ch3", got_frame(0), got_frame(1));
            miscompares++;
        end
    endtask

    task automatic test_burst_limit();
        int ch;
        int idx;
        apply_reset();
        for (int i = 0; i < 20; i++) push(0, mk_word(0, i));
        push(1, mk_word(1, 0));
        collect(84, 2000);
        vectors++;
        if (timed_out) begin
            $display("FAIL burst_timeout: got %0d beats, required 84", cap_data.size());
            miscompares++;
        end
        for (int f = 0; f < 21; f++) begin
            ch  = (f == 16) ? 1 : 0;
            idx = (f < 16) ? f : ((f == 16) ? 0 : f - 1);
            vectors++;
            if (got_frame(f) !== exp_frame(mk_word(ch, idx), 2'(ch)) || got_last(f) !== 4'b0001) begin
                $display("FAIL burst_frame%0d: got %h, required %h", f, got_frame(f), exp_frame(mk_word(ch, idx), 2'(ch)));
                miscompares++;
            end
            $display("burst frame %0d ch=%0d header=%h", f, cap_data[4*f][27:26], cap_data[4*f]);
        end
        @(negedge clk160);
        vectors++;
        if (frame_count !== 16'd21 || busy !== 1'b0) begin
            $display("FAIL burst_count: fc=%0d busy=%b, required 21/0", frame_count, busy);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_b [4];
        int idx;
        int stall;
        int it;
        int fc0;
        exp_b = '{32'hA8123456, 32'h789ABCDE, 32'hF0112233, 32'h44556677};
        fc0 = frame_count;
        idx = 0;
        stall = 5;
        it = 0;
        push(2, SPEC_WORD);
        while (idx < 4 && it < 200) begin
            @(negedge clk160);
            it++;
            if (out_valid) begin
                if (idx == 1 && stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                    vectors++;
                    if (out_data !== exp_b[1] || out_last !== 1'b0) begin
                        $display("FAIL bp_hold: data=%h last=%b, required %h last=0", out_data, out_last, exp_b[1]);
                        miscompares++;
                    end
                end else begin
                    out_ready = 1'b1;
                    vectors++;
                    if (out_data !== exp_b[idx] || out_last !== (idx == 3)) begin
                        $display("FAIL bp_beat%0d: data=%h last=%b, required %h last=%b", idx, out_data, out_last, exp_b[idx], idx == 3);
                        miscompares++;
                    end
                    $display("backpressure beat %0d data=%h", idx, out_data);
                    idx++;
                end
            end
        end
        @(negedge clk160);
        vectors++;
        if (idx != 4 || frame_count !== 16'(fc0 + 1) || out_valid !== 1'b0) begin
            $display("FAIL bp_count: beats=%0d fc=%0d valid=%b, required 4/%0d/0", idx, frame_count, out_valid, fc0 + 1);
            miscompares++;
        end
    endtask

    task automatic test_enable_reset();
        int s1;
        int fc0;
        s1  = strobe_cnt[1];
        fc0 = frame_count;
        chan_enable = 4'b1101;
        push(1, mk_word(1, 0));
        push(3, mk_word(3, 0));
        collect(4, 100);
        vectors++;
        if (timed_out || got_frame(0) !== exp_frame(mk_word(3, 0), 2'd3)) begin
            $display("FAIL en_frame: got %h, required %h", got_frame(0), exp_frame(mk_word(3, 0), 2'd3));
            miscompares++;
        end
        repeat (20) @(negedge clk160);
        vectors++;
        if (frame_count !== 16'(fc0 + 1) || busy !== 1'b0 || strobe_cnt[1] != s1) begin
            $display("FAIL en_disabled: fc=%0d busy=%b ch1_strobes=%0d, required %0d/0/%0d", frame_count, busy, strobe_cnt[1], fc0 + 1, s1);
            miscompares++;
        end
        push(2, mk_word(2, 1));
        collect(4, 100);
        vectors++;
        if (timed_out || got_frame(0) !== exp_frame(mk_word(2, 1), 2'd2)) begin
            $display("FAIL en_ch2: got %h, required %h", got_frame(0), exp_frame(mk_word(2, 1), 2'd2));
            miscompares++;
        end
        // Abort a ch3 frame while beat 2 is on the bus; reset must act without a clock edge.
        push(3, mk_word(3, 1));
        collect(2, 100);
        @(negedge clk160);
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_last, out_data, busy, grant_ch, frame_count, channel_data_read} !== '0) begin
            $display("FAIL async_reset: valid=%b fc=%0d busy=%b data=%h, required all zero", out_valid, frame_count, busy, out_data);
            miscompares++;
        end
        @(negedge clk160);
        reset_n = 1'b1;
        repeat (10) @(negedge clk160);
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || strobe_cnt[1] != s1) begin
            $display("FAIL post_reset_idle: busy=%b valid=%b ch1_strobes=%0d, required 0/0/%0d", busy, out_valid, strobe_cnt[1], s1);
            miscompares++;
        end
        // Pointer must be back at 0: pending ch1 wins over ch3.
        chan_enable = 4'hF;
        push(3, mk_word(3, 2));
        collect(8, 200);
        vectors++;
        if (timed_out || got_frame(0) !== exp_frame(mk_word(1, 0), 2'd1) ||
            got_frame(1) !== exp_frame(mk_word(3, 2), 2'd3)) begin
            $display("FAIL post_reset_rr: frames %h / %h, required ch1 then ch3", got_frame(0), got_frame(1));
            miscompares++;
        end
        @(negedge clk160);
        vectors++;
        if (frame_count !== 16'd2) begin
            $display("FAIL post_reset_count: fc=%0d, required 2", frame_count);
            miscompares++;
        end
    endtask

    task automatic test_strobe_protocol();
        vectors++;
        if (strobe_err != 0) begin
            $display("FAIL strobe_protocol: %0d bad strobes, required 0", strobe_err);
            miscompares++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        out_ready = 1'b1;
        chan_enable = 4'hF;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_burst_limit();
        test_backpressure();
        test_enable_reset();
        test_strobe_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
